// File: rtl/parking.sv
`default_nettype none
// parking: car-park occupancy counter driven by an outer (a) and inner (b) beam sensor.
// Entry a,ab,b,clear adds one car; exit b,ab,a,clear removes one; count saturates at 0 and CAPACITY.
module parking #(
    parameter int CAPACITY = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic [7:0] count
);

    localparam logic [7:0] CAP = 8'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_BA = 3'd5,
        EX_A  = 3'd6,
        WAIT  = 3'd7
    } state_t;

    logic       a_meta;
    logic       a_sync;
    logic       b_meta;
    logic       b_sync;
    logic [1:0] pat;
    logic       inc;
    logic       dec;
    state_t     state;
    state_t     next_state;

    // Raw sensors are asynchronous; two flops each before the FSM sees them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= a;
            a_sync <= a_meta;
            b_meta <= b;
            b_sync <= b_meta;
        end
    end

    assign pat = {a_sync, b_sync};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        inc        = 1'b0;
        dec        = 1'b0;
        case (state)
            IDLE: begin
                case (pat)
                    2'b10:   next_state = EN_A;
                    2'b01:   next_state = EX_B;
                    2'b11:   next_state = WAIT;
                    default: next_state = IDLE;
                endcase
            end
            EN_A: begin
                case (pat)
                    2'b11:   next_state = EN_AB;
                    2'b00:   next_state = IDLE;
                    2'b01:   next_state = WAIT;
                    default: next_state = EN_A;
                endcase
            end
            EN_AB: begin
                case (pat)
                    2'b01:   next_state = EN_B;
                    2'b10:   next_state = EN_A;
                    2'b00:   next_state = IDLE;
                    default: next_state = EN_AB;
                endcase
            end
            EN_B: begin
                case (pat)
                    2'b11:   next_state = EN_AB;
                    2'b10:   next_state = WAIT;
                    2'b00: begin
                        next_state = IDLE;
                        inc        = 1'b1;
                    end
                    default: next_state = EN_B;
                endcase
            end
            EX_B: begin
                case (pat)
                    2'b11:   next_state = EX_BA;
                    2'b00:   next_state = IDLE;
                    2'b10:   next_state = WAIT;
                    default: next_state = EX_B;
                endcase
            end
            EX_BA: begin
                case (pat)
                    2'b10:   next_state = EX_A;
                    2'b01:   next_state = EX_B;
                    2'b00:   next_state = IDLE;
                    default: next_state = EX_BA;
                endcase
            end
            EX_A: begin
                case (pat)
                    2'b11:   next_state = EX_BA;
                    2'b01:   next_state = WAIT;
                    2'b00: begin
                        next_state = IDLE;
                        dec        = 1'b1;
                    end
                    default: next_state = EX_A;
                endcase
            end
            WAIT: begin
                if (pat == 2'b00) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Out-of-range updates are dropped so the count never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (inc && (count != CAP)) begin
            count <= count + 8'd1;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking.sv
`default_nettype none
// tb_parking: scoreboard bench for parking at CAPACITY 255 and CAPACITY 3 side by side.
module tb_parking;

    logic       clk;
    logic       reset;
    logic       a;
    logic       b;
    logic [7:0] count;
    logic [7:0] count3;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt3 = 0;

    typedef struct {
        string tag;
        int    e;
        int    e3;
    } sb_item_t;

    sb_item_t sb[$];

    parking dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .count(count)
    );

    parking #(.CAPACITY(3)) dut_cap3 (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .count(count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] p, input int n);
        {a, b} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input string tag);
        sb.push_back('{tag, exp_cnt, exp_cnt3});
    endtask

    task automatic pop_check();
        sb_item_t item;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            item = sb.pop_front();
            check({item.tag, "_cap255"}, int'(count), item.e);
            check({item.tag, "_cap3"}, int'(count3), item.e3);
        end
    endtask

    task automatic entry_seq(input string tag);
        drive(2'b10, 2);
        drive(2'b11, 2);
        drive(2'b01, 2);
        drive(2'b00, 4);
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt3 < 3) exp_cnt3++;
        push_exp(tag);
        pop_check();
    endtask

    task automatic exit_seq(input string tag);
        drive(2'b01, 2);
        drive(2'b11, 2);
        drive(2'b10, 2);
        drive(2'b00, 4);
        if (exp_cnt > 0) exp_cnt--;
        if (exp_cnt3 > 0) exp_cnt3--;
        push_exp(tag);
        pop_check();
    endtask

    initial begin
        reset = 1'b0;
        a     = 1'b1;
        b     = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("reset");
        pop_check();

        {a, b} = 2'b00;
        reset  = 1'b1;
        repeat (4) @(negedge clk);
        push_exp("release");
        pop_check();

        // First entry: count must still be 0 after two edges of 00 and 1 after the third.
        drive(2'b10, 2);
        drive(2'b11, 2);
        drive(2'b01, 2);
        drive(2'b00, 2);
        check("edge2_hold", int'(count), 0);
        @(negedge clk);
        check("edge3_inc", int'(count), 1);
        drive(2'b00, 1);
        exp_cnt  = 1;
        exp_cnt3 = 1;
        push_exp("entry1");
        pop_check();

        for (int i = 2; i <= 5; i++) entry_seq($sformatf("entry%0d", i));

        exit_seq("exit_from5");

        drive(2'b10, 2);
        drive(2'b11, 2);
        drive(2'b10, 2);
        drive(2'b00, 4);
        push_exp("backout");
        pop_check();

        for (int i = 0; i < 4; i++) exit_seq($sformatf("exit_down%0d", i));
        exit_seq("exit_at_zero");

        drive(2'b11, 2);
        drive(2'b01, 2);
        drive(2'b00, 4);
        push_exp("illegal");
        pop_check();
        entry_seq("wait_recover");

        for (int i = 0; i < 6; i++) entry_seq($sformatf("fill%0d", i));

        // Park the FSM in EN_AB, then reset between clock edges.
        drive(2'b10, 2);
        drive(2'b11, 4);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        exp_cnt  = 0;
        exp_cnt3 = 0;
        push_exp("async_reset");
        pop_check();
        @(negedge clk);
        {a, b} = 2'b01;
        reset  = 1'b1;
        drive(2'b01, 2);
        drive(2'b00, 4);
        push_exp("post_reset_partial");
        pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
